// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the unified byte-wide RAM port controller: length codes,
// owner encoding, sequencer states and the RAM read latency.
package mem_ctrl_pkg;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StXfer = 2'd1;
    localparam logic [1:0] StLast = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned RAM_RD_LAT = 1;

    // The reserved length code 2 is serviced as a full word
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            LEN_WORD: len_bytes = 3'd4;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the fetch and load/store requesters and mem_ctrl.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_req;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  if_data, if_done, mem_rdata, mem_done, stall_req
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output if_data, if_done, mem_rdata, mem_done, stall_req
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Two-way grant picker for the RAM port. Fixed MEM-over-IF priority by default;
// round-robin on ties when MEM_CTRL_RR_EN is defined.
module mem_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_mem,
    input  logic accept,
    output logic grant
);

    logic last_q;

`ifdef MEM_CTRL_RR_EN
    always_comb begin
        if (req_if && req_mem) begin
            grant = (last_q == OWN_IF) ? OWN_MEM : OWN_IF;
        end else begin
            grant = req_mem ? OWN_MEM : OWN_IF;
        end
    end
`else
    // With nothing pending the grant simply rests on the previous owner
    always_comb begin
        grant = req_mem ? OWN_MEM : (req_if ? OWN_IF : last_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= OWN_IF;
        end else if (accept) begin
            last_q <= grant;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter and byte sequencer for the shared byte-wide RAM port (fetch + load/store).
// Build option: MEM_CTRL_RR_EN selects round-robin arbitration in mem_arb.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    logic [1:0]        state_q;
    logic              owner_q, we_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        n_q, cnt_q;
    logic [31:0]       wdata_q, asm_q, asm_d;
    logic [31:0]       if_data_q, mem_rdata_q;
    logic              if_done_q, mem_done_q;

    logic              grant, accept;
    logic [ADDR_W-1:0] addr_sel;
    logic [2:0]        n_sel;
    logic              we_sel;
    logic [31:0]       wdata_sel;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic              unused_addr;

    assign accept = (state_q == StIdle) && (bus.if_req || bus.mem_req);

    mem_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_if  (bus.if_req),
        .req_mem (bus.mem_req),
        .accept  (accept),
        .grant   (grant)
    );

    always_comb begin
        if (grant == OWN_MEM) begin
            addr_sel  = bus.mem_addr[ADDR_W-1:0];
            n_sel     = len_bytes(bus.mem_len);
            we_sel    = bus.mem_we;
            wdata_sel = bus.mem_wdata;
        end else begin
            addr_sel  = bus.if_addr[ADDR_W-1:0];
            n_sel     = 3'd4;
            we_sel    = 1'b0;
            wdata_sel = '0;
        end
    end

    assign unused_addr = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

    // Read byte k-1 lands on ram_din one cycle after its address; the tail arrives in StLast
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = 2'd0;
        if (state_q == StXfer && !we_q && cnt_q > 3'(RAM_RD_LAT)) begin
            cap_en  = 1'b1;
            cap_idx = 2'(cnt_q - 3'(RAM_RD_LAT) - 3'd1);
        end else if (state_q == StLast) begin
            cap_en  = 1'b1;
            cap_idx = 2'(n_q - 3'd1);
        end
        asm_d = asm_q;
        if (cap_en) begin
            asm_d[{cap_idx, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            base_q      <= '0;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_dout    <= 8'd0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            asm_q      <= asm_d;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        owner_q  <= grant;
                        base_q   <= addr_sel;
                        n_q      <= n_sel;
                        we_q     <= we_sel;
                        wdata_q  <= wdata_sel;
                        cnt_q    <= 3'd1;
                        asm_q    <= '0;
                        ram_addr <= addr_sel;
                        ram_we   <= we_sel;
                        ram_dout <= wdata_sel[7:0];
                        state_q  <= StXfer;
                    end
                end
                StXfer: begin
                    if (cnt_q == n_q) begin
                        ram_we  <= 1'b0;
                        state_q <= we_q ? StDone : StLast;
                        if (we_q) begin
                            if (owner_q == OWN_MEM) mem_done_q <= 1'b1;
                            else                    if_done_q  <= 1'b1;
                        end
                    end else begin
                        ram_addr <= base_q + ADDR_W'(cnt_q);
                        ram_dout <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_q    <= cnt_q + 3'd1;
                    end
                end
                StLast: begin
                    state_q <= StDone;
                    if (owner_q == OWN_MEM) begin
                        mem_done_q  <= 1'b1;
                        mem_rdata_q <= asm_d;
                    end else begin
                        if_done_q <= 1'b1;
                        if_data_q <= asm_d;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.if_data   = if_data_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.stall_req = bus.if_req & ~if_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random transactions
// checked against a byte-array reference memory and per-transaction timing rules.
module tb_mem_ctrl;
    localparam int AW = 17;
    localparam int MSIZE = 1 << AW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    mem_ctrl_if bus ();

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: initial image plus an overlay of bytes written by the DUT
    logic [7:0] init_mem [MSIZE];
    logic [7:0] ref_mem  [MSIZE];
    logic [7:0] wr_dat   [MSIZE];
    bit         wr_val   [MSIZE];

    function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
        return wr_val[a] ? wr_dat[a] : init_mem[a];
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            wr_val[ram_addr] <= 1'b1;
            wr_dat[ram_addr] <= ram_dout;
        end
        ram_din <= ram_rd(ram_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] b, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[AW'(b + i)]) << (8 * i);
        return v;
    endfunction

    task automatic ref_write(input logic [AW-1:0] b, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) ref_mem[AW'(b + i)] = 8'(d >> (8 * i));
    endtask

    // Starts at a negedge in an idle cycle and ends at a negedge of the following idle cycle
    task automatic txn(input bit is_mem, input bit we_in, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
        int n, lat, k;
        bit we;
        logic [AW-1:0] base;
        logic [31:0] exp;
        we   = is_mem & we_in;
        n    = is_mem ? nbytes(len) : 4;
        lat  = n + (we ? 1 : 2);
        base = addr[AW-1:0];
        exp  = ref_read(base, n);
        if (is_mem) begin
            bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
            bus.mem_addr = addr; bus.mem_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            k = (c <= n) ? c : n;
            chk("ram_addr", 32'(ram_addr), 32'(AW'(base + k - 1)));
            chk("ram_we", 32'(ram_we), 32'(we && c <= n));
            if (we && c <= n) chk("ram_dout", 32'(ram_dout), 32'(8'(wdata >> (8 * (c - 1)))));
            chk(is_mem ? "mem_done" : "if_done",
                32'(is_mem ? bus.mem_done : bus.if_done), 32'(c == lat));
            chk("other_done", 32'(is_mem ? bus.if_done : bus.mem_done), 32'd0);
            chk("stall_req", 32'(bus.stall_req), 32'(!is_mem && c < lat));
        end
        if (we) begin
            ref_write(base, wdata, n);
            for (int i = 0; i < n; i++)
                chk("ram_byte", 32'(ram_rd(AW'(base + i))), 32'(ref_mem[AW'(base + i)]));
        end else begin
            chk(is_mem ? "mem_rdata" : "if_data", is_mem ? bus.mem_rdata : bus.if_data, exp);
        end
        bus.if_req = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        if (!we) chk("data_hold", is_mem ? bus.mem_rdata : bus.if_data, exp);
    endtask

    // Counts negedges until the owner's done pulse, bounded
    task automatic wait_done(input bit is_mem, input int exp_cyc, input string tag);
        int cnt = 0;
        bit seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            seen = is_mem ? bus.mem_done : bus.if_done;
        end
        chk(tag, cnt, exp_cyc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.if_req = 1'b0;
        bus.mem_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] e_a, e_b, ra, rwd;
    logic [1:0]  rl;
    bit          rm, rw, seen_done;

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            init_mem[16 + i] = 8'(32'h12345678 >> (8 * i));
            ref_mem[16 + i]  = init_mem[16 + i];
            init_mem[AW'(32'h1FFFF + i)] = 8'(32'h44332211 >> (8 * i));
            ref_mem[AW'(32'h1FFFF + i)]  = init_mem[AW'(32'h1FFFF + i)];
        end
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        rst = 1'b1;

        txn(1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'd0);
        chk("fetch_word", bus.if_data, 32'h12345678);

        txn(1'b1, 1'b1, 2'd1, 32'h0000_0021, 32'hAABBCCDD);
        txn(1'b1, 1'b0, 2'd0, 32'h0000_0022, 32'd0);
        chk("load_byte_cc", bus.mem_rdata, 32'h0000_00CC);

        txn(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'd0);
        chk("wrap_word", bus.mem_rdata, 32'h44332211);

        // Contention from a fresh reset so the last-grant flop starts at IF
        do_reset();
        e_a = ref_read(AW'(32'h40), 4);
        e_b = ref_read(AW'(32'h80), 4);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_addr = 32'h80;
        wait_done(1'b1, 6, "tie1_mem_lat");
        chk("tie1_mem_data", bus.mem_rdata, e_b);
        bus.mem_len = 2'd0; bus.mem_addr = 32'h90;
        e_b = ref_read(AW'(32'h90), 1);
`ifdef MEM_CTRL_RR_EN
        wait_done(1'b0, 7, "tie2_if_lat");
        chk("tie2_if_data", bus.if_data, e_a);
        bus.if_req = 1'b0;
        wait_done(1'b1, 4, "tie2_mem_lat");
        chk("tie2_mem_data", bus.mem_rdata, e_b);
        bus.mem_req = 1'b0;
`else
        wait_done(1'b1, 4, "tie2_mem_lat");
        chk("tie2_mem_data", bus.mem_rdata, e_b);
        bus.mem_req = 1'b0;
        wait_done(1'b0, 7, "tie2_if_lat");
        chk("tie2_if_data", bus.if_data, e_a);
        bus.if_req = 1'b0;
`endif
        @(negedge clk);

        // Abort a fetch in C3
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.if_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_ram_dout", 32'(ram_dout), 32'd0);
        chk("abort_if_done", 32'(bus.if_done), 32'd0);
        chk("abort_if_data", bus.if_data, 32'd0);
        chk("abort_mem_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_done |= bus.if_done;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        txn(1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'd0);
        chk("refetch_word", bus.if_data, 32'h12345678);

        // Fetch requester drops in C2; a store arriving meanwhile follows after one idle
        e_a = ref_read(AW'(32'h30), 4);
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        @(posedge clk);
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
        bus.mem_addr = 32'h0001_FFFE; bus.mem_wdata = 32'h0000_005A;
        @(negedge clk);
        bus.if_req = 1'b0;
        wait_done(1'b0, 4, "drop_if_lat");
        chk("drop_if_data", bus.if_data, e_a);
        ref_write(AW'(32'h1FFFE), 32'h5A, 1);
        wait_done(1'b1, 3, "drop_mem_lat");
        bus.mem_req = 1'b0;
        chk("drop_mem_byte", 32'(ram_rd(AW'(32'h1FFFE))), 32'h5A);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            rm  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rl  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rwd = $urandom;
            if ($urandom_range(0, 3) == 0) ra[AW-1:0] = AW'(32'h1FFFC + $urandom_range(0, 3));
            txn(rm, rw, rl, ra, rwd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
